// File: rtl/mul_appr_booth_seq.sv
// Sequential radix-4 Booth multiplier, exact or low-column-truncated, result >>> SHIFT_WIDTH.
// Latency: WIDTH/2 cycles from accept to out_valid; one operation per WIDTH/2+2 cycles.
// Backpressure: in_ready only in IDLE (no buffering); result held in DONE until out_ready.
module mul_appr_booth_seq #(
    parameter int WIDTH       = 16,
    parameter int SHIFT_WIDTH = 8,
    parameter int APPR_COLS   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 appr_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out
);

    localparam int P     = 2 * WIDTH;
    localparam int NDIG  = WIDTH / 2;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);
    localparam logic [P-1:0]     ONE_P    = {{(P-1){1'b0}}, 1'b1};
    // Keeps the columns at and above APPR_COLS; APPR_COLS=0 keeps everything,
    // APPR_COLS=P clears everything (the shift then yields 0, minus one is all-ones).
    localparam logic [P-1:0]     KEEP_MASK = ~((ONE_P << APPR_COLS) - ONE_P);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [P-1:0]     a_sh_q, a_sh_d;    // sign-extended multiplicand, pre-shifted by 2i
    logic [WIDTH:0]   b_sh_q, b_sh_d;    // {b, 0}; low 3 bits are the current Booth triplet
    logic             appr_q, appr_d;
    logic [P-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [P-1:0]     out_q, out_d;

    logic [2:0]       trip;
    logic [P-1:0]     pp;
    logic [P-1:0]     pp_eff;
    logic [P-1:0]     acc_sum;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)          state_d = S_RUN;
            S_RUN:   if (cnt_q == LAST_DIG) state_d = S_DONE;
            S_DONE:  if (out_ready)         state_d = S_IDLE;
            default:                        state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        out       = out_q;
    end

    // Booth digit selection and partial-product accumulation for the current digit
    always_comb begin
        trip = b_sh_q[2:0];
        case (trip)
            3'b001, 3'b010: pp = a_sh_q;
            3'b011:         pp = a_sh_q << 1;
            3'b100:         pp = {P{1'b0}} - (a_sh_q << 1);
            3'b101, 3'b110: pp = {P{1'b0}} - a_sh_q;
            default:        pp = {P{1'b0}};
        endcase
        // Clearing low bits of a two's-complement value floors it, so approx <= exact.
        pp_eff  = appr_q ? (pp & KEEP_MASK) : pp;
        acc_sum = acc_q + pp_eff;
    end

    // Datapath next values: load on accept, step one digit per RUN cycle, latch result on exit
    always_comb begin
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        appr_d = appr_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sh_d = {{WIDTH{a[WIDTH-1]}}, a};
                    b_sh_d = {b, 1'b0};
                    appr_d = appr_en;
                    acc_d  = {P{1'b0}};
                    cnt_d  = {CNT_W{1'b0}};
                end
            end
            S_RUN: begin
                acc_d  = acc_sum;
                cnt_d  = cnt_q + CNT_W'(1);
                a_sh_d = a_sh_q << 2;
                b_sh_d = b_sh_q >> 2;
                if (cnt_q == LAST_DIG) begin
                    out_d = $signed(acc_sum) >>> SHIFT_WIDTH;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q <= {P{1'b0}};
            b_sh_q <= {(WIDTH+1){1'b0}};
            appr_q <= 1'b0;
            acc_q  <= {P{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
            out_q  <= {P{1'b0}};
        end else begin
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
            appr_q <= appr_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

endmodule

// File: tb/tb_mul_appr_booth_seq.sv
// Directed and random checks of mul_appr_booth_seq at WIDTH=16, SHIFT_WIDTH=8, APPR_COLS=8.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Expected values are hand-computed constants or a 64-bit integer reference product.
module tb_mul_appr_booth_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        appr_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_o;

    int errors = 0;
    int checks = 0;

    mul_appr_booth_seq #(.WIDTH(16), .SHIFT_WIDTH(8), .APPR_COLS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .appr_en   (appr_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected range [%0d,%0d]", tag, obs, lo, hi);
        end
    endtask

    function automatic logic [31:0] ref_exact(input logic [15:0] x, input logic [15:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return 32'(p >>> 8);
    endfunction

    // Present operands for one edge (caller ensures the DUT is idle)
    task automatic launch(input logic [15:0] x, input logic [15:0] y, input logic ap);
        a_i = x; b_i = y; appr_en = ap; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid, bounded
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (out_valid !== 1'b1) begin
            errors++;
            checks++;
            $error("FAIL timeout waiting for out_valid observed=%b expected=1", out_valid);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic ap,
                         output logic [31:0] r, output int cyc);
        launch(x, y, ap);
        wait_valid(cyc);
        r = out_o;
        drain();
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] r_ex;
        logic [31:0] held;
        logic [15:0] rx;
        logic [15:0] ry;
        int          cyc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_i = '0; b_i = '0; appr_en = 1'b0;
        #12;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out", out_o, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // 3.0 * 2.0 in Q8.8
        do_op(16'h0300, 16'h0200, 1'b0, r, cyc);
        chk("q88 3*2", r, 32'h0000_0600);
        chk("latency", 32'(cyc), 32'd8);
        chk("idle after drain", {31'd0, in_ready}, 32'd1);
        chk("out holds in idle", out_o, 32'h0000_0600);

        // 1000 * -494: exact -1930; truncated digits give -494336 raw -> -1931
        do_op(16'd1000, 16'hFE12, 1'b0, r, cyc);
        chk("1000*-494 exact", r, 32'hFFFF_F876);
        do_op(16'd1000, 16'hFE12, 1'b1, r, cyc);
        chk_rng("1000*-494 approx range", int'($signed(r)), -1938, -1930);
        chk("1000*-494 approx value", r, 32'hFFFF_F875);

        // Corner products
        do_op(16'h8000, 16'h8000, 1'b0, r, cyc);
        chk("min*min", r, 32'h0040_0000);
        do_op(16'h7FFF, 16'h8000, 1'b0, r, cyc);
        chk("max*min", r, 32'hFFC0_0080);
        do_op(16'h8000, 16'h8000, 1'b1, r, cyc);
        chk("min*min approx (no low bits)", r, 32'h0040_0000);

        // a = 1.0: partial products have no low bits set, approx equals exact
        for (int i = 0; i < 600; i++) begin
            ry = 16'($urandom);
            do_op(16'h0100, ry, 1'b1, r, cyc);
            chk("a=0x100 approx==exact", r, ref_exact(16'h0100, ry));
        end

        // Backpressure in DONE
        launch(16'h0300, 16'hFF00, 1'b0);   // 3.0 * -1.0
        wait_valid(cyc);
        held = out_o;
        chk("bp value", held, 32'hFFFF_FD00);
        for (int i = 0; i < 5; i++) begin
            a_i = 16'h1234; b_i = 16'h4321; in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            chk("bp out stable", out_o, held);
            chk("bp out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        drain();
        chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp release out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp ignored operand", out_o, held);

        // Asynchronous reset in the middle of RUN
        launch(16'h7FFF, 16'h7FFF, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("mid-run rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid-run rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid-run rst out", out_o, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        do_op(16'hFD80, 16'h0140, 1'b0, r, cyc);   // -2.5 * 1.25 = -3.125
        chk("after rst", r, 32'hFFFF_FCE0);

        // Random regression: exact matches reference; approx within floor bound
        for (int i = 0; i < 1000; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            r_ex = ref_exact(rx, ry);
            do_op(rx, ry, 1'b0, r, cyc);
            chk("rand exact", r, r_ex);
            do_op(rx, ry, 1'b1, r, cyc);
            chk_rng("rand approx diff", int'($signed(r_ex)) - int'($signed(r)), 0, 8);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
